// File: rtl/pipe_stage_buf.sv
// pipe_stage_buf: valid/ready pipeline stage register carrying an opaque
// payload word and a control word. When SKID=1, a second entry register lets
// in_ready come straight from a flop.
module pipe_stage_buf #(
   parameter int unsigned DATA_W = 128,
   parameter int unsigned CTRL_W = 16,
   parameter int unsigned SKID   = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic [CTRL_W-1:0] in_ctrl,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [1:0]        count
);

   // Head entry: always the oldest held entry, driven straight to the outputs.
   logic              head_valid;
   logic [DATA_W-1:0] head_data;
   logic [CTRL_W-1:0] head_ctrl;
   logic              head_valid_nx;
   logic [DATA_W-1:0] head_data_nx;
   logic [CTRL_W-1:0] head_ctrl_nx;

   logic accept;
   logic pop;

   assign accept    = in_valid & in_ready;
   assign pop       = head_valid & out_ready;

   assign out_valid = head_valid;
   assign out_data  = head_data;
   assign out_ctrl  = head_ctrl;

   // Head register; head_ctrl is kept zero whenever head_valid is low.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head_valid <= 1'b0;
         head_data  <= '0;
         head_ctrl  <= '0;
      end else begin
         head_valid <= head_valid_nx;
         head_data  <= head_data_nx;
         head_ctrl  <= head_ctrl_nx;
      end
   end

   if (SKID == 0) begin : g_single

      // No spare entry, so a slot frees up in the same cycle the head pops.
      assign in_ready = ~head_valid | out_ready;
      assign count    = {1'b0, head_valid};

      // Next head: flush wins, then load, then drain to a bubble.
      always_comb begin
         head_valid_nx = head_valid;
         head_data_nx  = head_data;
         head_ctrl_nx  = head_ctrl;
         if (flush) begin
            head_valid_nx = 1'b0;
            head_data_nx  = '0;
            head_ctrl_nx  = '0;
         end else if (accept) begin
            head_valid_nx = 1'b1;
            head_data_nx  = in_data;
            head_ctrl_nx  = in_ctrl;
         end else if (pop) begin
            head_valid_nx = 1'b0;
            head_ctrl_nx  = '0;
         end
      end

   end else begin : g_skid

      logic              skid_valid;
      logic [DATA_W-1:0] skid_data;
      logic [CTRL_W-1:0] skid_ctrl;
      logic              skid_valid_nx;
      logic [DATA_W-1:0] skid_data_nx;
      logic [CTRL_W-1:0] skid_ctrl_nx;
      logic              ready_q;
      logic              ready_nx;

      assign in_ready = ready_q;
      assign count    = 2'(head_valid) + 2'(skid_valid);

      // Next head/skid state. The skid only fills while the head is stalled,
      // so the skid is never occupied while the head is empty.
      always_comb begin
         head_valid_nx = head_valid;
         head_data_nx  = head_data;
         head_ctrl_nx  = head_ctrl;
         skid_valid_nx = skid_valid;
         skid_data_nx  = skid_data;
         skid_ctrl_nx  = skid_ctrl;
         ready_nx      = ready_q;
         if (flush) begin
            head_valid_nx = 1'b0;
            head_data_nx  = '0;
            head_ctrl_nx  = '0;
            skid_valid_nx = 1'b0;
            skid_data_nx  = '0;
            skid_ctrl_nx  = '0;
            ready_nx      = 1'b1;
         end else if (skid_valid) begin
            // in_ready is low here, so the only possible event is a pop.
            if (pop) begin
               head_valid_nx = 1'b1;
               head_data_nx  = skid_data;
               head_ctrl_nx  = skid_ctrl;
               skid_valid_nx = 1'b0;
               skid_data_nx  = '0;
               skid_ctrl_nx  = '0;
               ready_nx      = 1'b1;
            end
         end else if (accept) begin
            if (!head_valid || pop) begin
               head_valid_nx = 1'b1;
               head_data_nx  = in_data;
               head_ctrl_nx  = in_ctrl;
            end else begin
               skid_valid_nx = 1'b1;
               skid_data_nx  = in_data;
               skid_ctrl_nx  = in_ctrl;
               ready_nx      = 1'b0;
            end
         end else if (pop) begin
            head_valid_nx = 1'b0;
            head_ctrl_nx  = '0;
         end
      end

      // Skid entry and registered ready; ready is forced high while in reset.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            skid_valid <= 1'b0;
            skid_data  <= '0;
            skid_ctrl  <= '0;
            ready_q    <= 1'b1;
         end else begin
            skid_valid <= skid_valid_nx;
            skid_data  <= skid_data_nx;
            skid_ctrl  <= skid_ctrl_nx;
            ready_q    <= ready_nx;
         end
      end

   end

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Directed bench for pipe_stage_buf: one SKID=0 and one SKID=1 instance
// sharing upstream stimulus, each with its own out_ready.
module tb_pipe_stage_buf;

   localparam int unsigned DW = 32;
   localparam int unsigned CW = 16;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          flush;
   logic          in_valid;
   logic [DW-1:0] in_data;
   logic [CW-1:0] in_ctrl;

   logic          in_ready0, out_valid0, out_ready0;
   logic [DW-1:0] out_data0;
   logic [CW-1:0] out_ctrl0;
   logic [1:0]    count0;

   logic          in_ready1, out_valid1, out_ready1;
   logic [DW-1:0] out_data1;
   logic [CW-1:0] out_ctrl1;
   logic [1:0]    count1;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   pipe_stage_buf #(.DATA_W(DW), .CTRL_W(CW), .SKID(0)) u0 (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready0), .in_data(in_data), .in_ctrl(in_ctrl),
      .out_valid(out_valid0), .out_ready(out_ready0), .out_data(out_data0),
      .out_ctrl(out_ctrl0), .count(count0)
   );

   pipe_stage_buf #(.DATA_W(DW), .CTRL_W(CW), .SKID(1)) u1 (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready1), .in_data(in_data), .in_ctrl(in_ctrl),
      .out_valid(out_valid1), .out_ready(out_ready1), .out_data(out_data1),
      .out_ctrl(out_ctrl1), .count(count1)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_flush();
      flush    = 1'b1;
      in_valid = 1'b0;
      tick();
      flush    = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; in_ctrl = '0;
      out_ready0 = 1'b0; out_ready1 = 1'b0;
      repeat (3) tick();
      checks++; if (out_valid0 !== 1'b0 || out_ctrl0 !== '0 || out_data0 !== '0 || count0 !== 2'd0) begin
         errors++; $display("FAIL reset_u0: got v=%0b c=%0h d=%0h n=%0d expected 0", out_valid0, out_ctrl0, out_data0, count0); end
      checks++; if (out_valid1 !== 1'b0 || out_ctrl1 !== '0 || out_data1 !== '0 || count1 !== 2'd0) begin
         errors++; $display("FAIL reset_u1: got v=%0b c=%0h d=%0h n=%0d expected 0", out_valid1, out_ctrl1, out_data1, count1); end
      checks++; if (in_ready0 !== 1'b1 || in_ready1 !== 1'b1) begin
         errors++; $display("FAIL reset_ready: got %0b/%0b expected 1/1", in_ready0, in_ready1); end
      rst_n = 1'b1;
   endtask

   task automatic test_stream();
      out_ready0 = 1'b1; out_ready1 = 1'b1;
      in_valid = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         checks++; if (in_ready0 !== 1'b1 || in_ready1 !== 1'b1) begin
            errors++; $display("FAIL stream_ready[%0d]: got %0b/%0b expected 1/1", i, in_ready0, in_ready1); end
         in_data = DW'(i);
         in_ctrl = CW'(i);
         tick();
         checks++; if (out_valid0 !== 1'b1 || out_data0 !== DW'(i) || out_ctrl0 !== CW'(i)) begin
            errors++; $display("FAIL stream_u0[%0d]: got v=%0b d=%0h expected v=1 d=%0h", i, out_valid0, out_data0, i); end
         checks++; if (out_valid1 !== 1'b1 || out_data1 !== DW'(i) || out_ctrl1 !== CW'(i)) begin
            errors++; $display("FAIL stream_u1[%0d]: got v=%0b d=%0h expected v=1 d=%0h", i, out_valid1, out_data1, i); end
      end
      in_valid = 1'b0;
      tick();
      checks++; if (out_valid0 !== 1'b0 || out_ctrl0 !== '0 || out_data0 !== DW'(8)) begin
         errors++; $display("FAIL stream_drain_u0: got v=%0b c=%0h d=%0h expected v=0 c=0 d=8", out_valid0, out_ctrl0, out_data0); end
      checks++; if (out_valid1 !== 1'b0 || out_ctrl1 !== '0 || count1 !== 2'd0) begin
         errors++; $display("FAIL stream_drain_u1: got v=%0b c=%0h n=%0d expected 0", out_valid1, out_ctrl1, count1); end
   endtask

   task automatic test_backpressure_skid();
      do_flush();
      out_ready0 = 1'b1; out_ready1 = 1'b0;
      in_valid = 1'b1; in_data = DW'(32'hA); in_ctrl = CW'(16'h0A);
      tick();
      checks++; if (count1 !== 2'd1 || in_ready1 !== 1'b1 || out_data1 !== DW'(32'hA)) begin
         errors++; $display("FAIL bp_skid_a: got n=%0d r=%0b d=%0h expected n=1 r=1 d=a", count1, in_ready1, out_data1); end
      in_data = DW'(32'hB); in_ctrl = CW'(16'h0B);
      tick();
      checks++; if (count1 !== 2'd2 || in_ready1 !== 1'b0 || out_data1 !== DW'(32'hA)) begin
         errors++; $display("FAIL bp_skid_b: got n=%0d r=%0b d=%0h expected n=2 r=0 d=a", count1, in_ready1, out_data1); end
      in_data = DW'(32'hC); in_ctrl = CW'(16'h0C);
      tick();
      checks++; if (count1 !== 2'd2 || out_data1 !== DW'(32'hA) || out_ctrl1 !== CW'(16'h0A)) begin
         errors++; $display("FAIL bp_skid_hold: got n=%0d d=%0h c=%0h expected n=2 d=a c=a", count1, out_data1, out_ctrl1); end
      out_ready1 = 1'b1;
      tick();
      checks++; if (out_data1 !== DW'(32'hB) || count1 !== 2'd1 || in_ready1 !== 1'b1) begin
         errors++; $display("FAIL bp_skid_pop_b: got d=%0h n=%0d r=%0b expected d=b n=1 r=1", out_data1, count1, in_ready1); end
      tick();
      checks++; if (out_data1 !== DW'(32'hC) || out_valid1 !== 1'b1 || count1 !== 2'd1) begin
         errors++; $display("FAIL bp_skid_pop_c: got d=%0h v=%0b n=%0d expected d=c v=1 n=1", out_data1, out_valid1, count1); end
      in_valid = 1'b0;
      tick();
      checks++; if (out_valid1 !== 1'b0 || count1 !== 2'd0) begin
         errors++; $display("FAIL bp_skid_empty: got v=%0b n=%0d expected 0/0", out_valid1, count1); end
   endtask

   task automatic test_backpressure_single();
      do_flush();
      out_ready0 = 1'b1; out_ready1 = 1'b1;
      in_valid = 1'b1; in_data = DW'(32'h55); in_ctrl = CW'(16'h5);
      tick();
      in_data = DW'(32'h66); in_ctrl = CW'(16'h6);
      out_ready0 = 1'b0;
      #1;
      checks++; if (in_ready0 !== 1'b0) begin
         errors++; $display("FAIL bp_single_ready_drop: got %0b expected 0", in_ready0); end
      for (int i = 0; i < 4; i++) begin
         tick();
         checks++; if (out_valid0 !== 1'b1 || out_data0 !== DW'(32'h55) || out_ctrl0 !== CW'(16'h5)) begin
            errors++; $display("FAIL bp_single_hold[%0d]: got v=%0b d=%0h expected v=1 d=55", i, out_valid0, out_data0); end
      end
      out_ready0 = 1'b1;
      #1;
      checks++; if (in_ready0 !== 1'b1) begin
         errors++; $display("FAIL bp_single_ready_rise: got %0b expected 1", in_ready0); end
      tick();
      checks++; if (out_valid0 !== 1'b1 || out_data0 !== DW'(32'h66)) begin
         errors++; $display("FAIL bp_single_resume: got v=%0b d=%0h expected v=1 d=66", out_valid0, out_data0); end
      in_valid = 1'b0;
      tick();
      checks++; if (out_valid0 !== 1'b0 || count0 !== 2'd0) begin
         errors++; $display("FAIL bp_single_empty: got v=%0b n=%0d expected 0/0", out_valid0, count0); end
   endtask

   task automatic test_flush();
      do_flush();
      out_ready0 = 1'b1; out_ready1 = 1'b0;
      in_valid = 1'b1; in_ctrl = CW'(16'hFFFF); in_data = DW'(32'h1);
      tick();
      in_data = DW'(32'h2);
      tick();
      checks++; if (count1 !== 2'd2 || out_ctrl1 !== CW'(16'hFFFF)) begin
         errors++; $display("FAIL flush_setup: got n=%0d c=%0h expected n=2 c=ffff", count1, out_ctrl1); end
      flush = 1'b1; in_data = DW'(32'h77);
      #1;
      checks++; if (in_ready0 !== 1'b1) begin
         errors++; $display("FAIL flush_ready_u0: got %0b expected 1", in_ready0); end
      tick();
      flush = 1'b0; in_valid = 1'b0;
      checks++; if (out_valid1 !== 1'b0 || out_ctrl1 !== '0 || out_data1 !== '0 || count1 !== 2'd0 || in_ready1 !== 1'b1) begin
         errors++; $display("FAIL flush_u1: got v=%0b c=%0h d=%0h n=%0d r=%0b expected 0,0,0,0,1", out_valid1, out_ctrl1, out_data1, count1, in_ready1); end
      checks++; if (out_valid0 !== 1'b0 || out_ctrl0 !== '0 || out_data0 !== '0 || count0 !== 2'd0) begin
         errors++; $display("FAIL flush_u0: got v=%0b c=%0h d=%0h n=%0d expected 0", out_valid0, out_ctrl0, out_data0, count0); end
      out_ready1 = 1'b1;
      tick();
      checks++; if (out_valid0 !== 1'b0 || out_valid1 !== 1'b0) begin
         errors++; $display("FAIL flush_dropped: got v=%0b/%0b expected 0/0", out_valid0, out_valid1); end
   endtask

   task automatic test_async_reset();
      do_flush();
      out_ready1 = 1'b0;
      in_valid = 1'b1; in_ctrl = CW'(16'h1234); in_data = DW'(32'h1);
      tick();
      in_data = DW'(32'h2);
      tick();
      checks++; if (count1 !== 2'd2) begin
         errors++; $display("FAIL areset_setup: got n=%0d expected 2", count1); end
      #2;
      rst_n = 1'b0;
      #1;
      checks++; if (out_valid1 !== 1'b0 || out_ctrl1 !== '0 || count1 !== 2'd0 || in_ready1 !== 1'b1) begin
         errors++; $display("FAIL areset_u1: got v=%0b c=%0h n=%0d r=%0b expected 0,0,0,1", out_valid1, out_ctrl1, count1, in_ready1); end
      checks++; if (out_valid0 !== 1'b0 || count0 !== 2'd0) begin
         errors++; $display("FAIL areset_u0: got v=%0b n=%0d expected 0/0", out_valid0, count0); end
      in_valid = 1'b0;
      tick();
      rst_n = 1'b1;
   endtask

   task automatic test_back_to_back();
      do_flush();
      out_ready0 = 1'b1; out_ready1 = 1'b1;
      in_valid = 1'b1; in_data = DW'(32'h10); in_ctrl = CW'(16'h1);
      tick();
      in_data = DW'(32'h20); in_ctrl = CW'(16'h2);
      tick();
      checks++; if (out_valid0 !== 1'b1 || out_data0 !== DW'(32'h20) || count0 !== 2'd1) begin
         errors++; $display("FAIL b2b_u0: got v=%0b d=%0h n=%0d expected 1,20,1", out_valid0, out_data0, count0); end
      checks++; if (out_valid1 !== 1'b1 || out_data1 !== DW'(32'h20) || count1 !== 2'd1) begin
         errors++; $display("FAIL b2b_u1: got v=%0b d=%0h n=%0d expected 1,20,1", out_valid1, out_data1, count1); end
      in_valid = 1'b0;
      tick();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_stream();
      test_backpressure_skid();
      test_backpressure_single();
      test_flush();
      test_async_reset();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/pipe_stage_buf.md
Name: pipe_stage_buf

Overview:
- Parametrised successor to the fixed-field pipeline stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Carries one opaque payload word plus one control word between two pipeline stages using a valid/ready handshake.
- Supports stall (back-pressure), flush (bubble insertion) and an optional 2-entry skid buffer so that in_ready is registered.
- Instantiated between stages in place of hand-written per-field registers.

Parameters:
DATA_W, 128, payload width in bits (results, addresses, store data, offsets, register ids).
CTRL_W, 16, control width in bits (RegWrite, MemRead, MemWrite, Branch, ...); zeroed on flush.
SKID, 1, 0 = single register with combinational in_ready; 1 = 2-entry skid buffer with registered in_ready.

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
flush  in  1  synchronous flush; discards all held entries and the current input
in_valid  in  1  upstream presents an entry
in_ready  out  1  stage can accept an entry this cycle
in_data  in  DATA_W  upstream payload
in_ctrl  in  CTRL_W  upstream control
out_valid  out  1  downstream entry present
out_ready  in  1  downstream accepts this cycle
out_data  out  DATA_W  payload of head entry
out_ctrl  out  CTRL_W  control of head entry; all zero whenever out_valid=0
count  out  2  number of held entries (0..1 when SKID=0, 0..2 when SKID=1)

Behaviour:
- Transfer rules: accept = in_valid & in_ready; pop = out_valid & out_ready. Both are evaluated at the rising edge.
- Reset (rst_n=0, asynchronous):
  - out_valid=0, out_data=0, out_ctrl=0, count=0.
  - SKID=1: skid entry cleared and in_ready=1 while in reset.
  - SKID=0: in_ready follows its combinational equation.
  - On deassertion, the first accept can occur on the next rising edge.
- Flush (synchronous, highest priority):
  - At the edge where flush=1, all entries are cleared: out_valid=0, data/ctrl=0, count=0.
  - An input presented in the same cycle is dropped, even though in_ready may read 1.
  - A pop in that cycle still counts as completed by downstream.
- SKID=0 (single register):
  - in_ready = ~out_valid | out_ready (combinational).
  - Accept loads in_data/in_ctrl into the head with latency 1.
  - Pop without accept → out_valid=0 and out_ctrl=0; out_data retains its last value.
  - Simultaneous pop and accept → head replaced, out_valid stays 1.
- SKID=1 (head + skid register):
  - in_ready = ~skid_valid, registered.
  - Empty + accept → head loaded, out_valid=1 next cycle.
  - Head full, no pop, accept → entry goes to skid; count=2; in_ready=0 next cycle.
  - Head full, pop and accept, skid empty → head replaced.
  - Skid full, pop → skid moves to head; skid cleared; in_ready=1 next cycle. No accept is possible that cycle because in_ready=0.
  - Ordering is strictly FIFO; no entry is duplicated or lost except under flush.
- Stall: out_ready=0 with out_valid=1 holds out_data and out_ctrl stable (the valid/ready stability rule).
- Bubble guarantee: out_ctrl == 0 whenever out_valid == 0, so downstream may ignore out_valid for write enables.
- count: updated at the same edge as the entries; never exceeds 1+SKID.
- Width rules:
  - DATA_W ≥ 1 and CTRL_W ≥ 1.
  - Payload is passed bit-exact with no sign or zero extension.
- Reset mid-operation: all entries are lost immediately, asynchronously, regardless of the handshake state.

Test Plan:
- Reset then stream: rst_n low 3 cycles, then in_valid=1 with in_data=0x1..0x8 on consecutive cycles, out_ready=1 → out_data 0x1..0x8 one cycle later each; out_valid continuous; in_ready constantly 1.
- Back-pressure (SKID=1): push 0xA, 0xB, 0xC with out_ready=0 → count=2 after 0xB; in_ready=0; 0xC held upstream. Then out_ready=1 → outputs 0xA, 0xB, 0xC in order with no loss.
- Back-pressure (SKID=0): out_ready=0 for 4 cycles with head=0x55 → out_data stays 0x55; in_ready=0 in the same cycle out_ready drops; resume → next entry appears after 1 cycle.
- Flush: count=2 holding ctrl=0xFFFF entries, flush=1 with in_valid=1, in_data=0x77 → next cycle out_valid=0, out_ctrl=0, count=0; 0x77 never appears at the output.
- Async reset mid-stall: count=2, pull rst_n low between edges → out_valid and out_ctrl=0 immediately, before the next edge; count=0.
- Simultaneous pop/accept at full head (SKID=0 and SKID=1): head 0x10, out_ready=1, in 0x20 → next cycle out_data=0x20, out_valid=1, count=1.
